// File: rtl/fpu_pkg.sv
// Shared definitions for the FP execute-stage hazard logic: forwarding select codes, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W      = 6;

  // Operand mux select codes; 2'b11 is never driven
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fpu_fwd_sel.sv
// Per-operand forwarding select: picks MEM, then WB, else register file for one EX source.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module fpu_fwd_sel
  import fpu_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_mem_wr,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
  output logic [1:0]        o_sel
);

  // MEM is the younger producer so it beats WB; f0 is an ordinary register here
  always_comb begin
    o_sel = FWD_RF;
    if (i_use && i_mem_wr && (i_mem_rd == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_use && i_wb_wr && (i_wb_rd == i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fpu_hazard_ctrl.sv
// FP execute hazard control: operand forwarding selects, load-use stall, FDIV/FSQRT sequencing.
// Latency: forwarding/stall combinational; mc_done follows mc_start by MC_CYCLES cycles.
// Backpressure: stall_id holds IF/ID for one load-use cycle and for the whole issue+BUSY window.
module fpu_hazard_ctrl
  import fpu_pkg::*;
#(
  parameter int MC_CYCLES = 12,
  parameter int REG_AW    = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rs3,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_use_rs3,
  input  logic              id_is_mc,
  input  logic              ex_is_fload,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_fp_wr,
  input  logic              wb_fp_wr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        forward_x,
  output logic [1:0]        forward_y,
  output logic [1:0]        forward_z,
  output logic              stall_id,
  output logic              mc_start,
  output logic              mc_busy,
  output logic              mc_done
);

  logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2, r_ex_rs3;
  logic              r_ex_use1, r_ex_use2, r_ex_use3, r_ex_mc;
  fsm_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              w_lu, w_issue;

  // Load-use: ID reads the register an FLW in EX is about to produce; masked while in reset
  assign w_lu = rst_n & id_valid & ex_is_fload &
                ((id_use_rs1 & (id_rs1 == ex_rd)) |
                 (id_use_rs2 & (id_rs2 == ex_rd)) |
                 (id_use_rs3 & (id_rs3 == ex_rd)));

  // A multi-cycle op sitting in EX launches this cycle unless it is being flushed
  assign w_issue = (r_state == ST_IDLE) & r_ex_mc & ~flush;

  // EX source copy: flush kills, BUSY holds, otherwise capture ID or insert a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_rs3  <= '0;
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
      r_ex_use3 <= 1'b0;
      r_ex_mc   <= 1'b0;
    end else if (flush) begin
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
      r_ex_use3 <= 1'b0;
      r_ex_mc   <= 1'b0;
    end else if (r_state != ST_BUSY) begin
      if (id_valid && !stall_id) begin
        r_ex_rs1  <= id_rs1;
        r_ex_rs2  <= id_rs2;
        r_ex_rs3  <= id_rs3;
        r_ex_use1 <= id_use_rs1;
        r_ex_use2 <= id_use_rs2;
        r_ex_use3 <= id_use_rs3;
        r_ex_mc   <= id_is_mc;
      end else begin
        r_ex_use1 <= 1'b0;
        r_ex_use2 <= 1'b0;
        r_ex_use3 <= 1'b0;
        r_ex_mc   <= 1'b0;
      end
    end
  end

  // Sequencer state and busy counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state: count loads MC_CYCLES-1 at issue and BUSY exits at 1, so it never wraps
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_BUSY;
          w_count_nxt = CNT_W'(MC_CYCLES - 1);
        end
      end
      ST_BUSY: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: DONE ignores flush because the result's writeback is already committed
  always_comb begin
    mc_start = w_issue;
    mc_busy  = (r_state == ST_BUSY);
    mc_done  = (r_state == ST_DONE);
    stall_id = w_lu | (r_state == ST_BUSY) | w_issue;
  end

  fpu_fwd_sel #(.REG_AW(REG_AW)) u_fwd_x (
    .i_use(r_ex_use1), .i_rs(r_ex_rs1),
    .i_mem_wr(mem_fp_wr), .i_mem_rd(mem_rd),
    .i_wb_wr(wb_fp_wr), .i_wb_rd(wb_rd),
    .o_sel(forward_x)
  );

  fpu_fwd_sel #(.REG_AW(REG_AW)) u_fwd_y (
    .i_use(r_ex_use2), .i_rs(r_ex_rs2),
    .i_mem_wr(mem_fp_wr), .i_mem_rd(mem_rd),
    .i_wb_wr(wb_fp_wr), .i_wb_rd(wb_rd),
    .o_sel(forward_y)
  );

  fpu_fwd_sel #(.REG_AW(REG_AW)) u_fwd_z (
    .i_use(r_ex_use3), .i_rs(r_ex_rs3),
    .i_mem_wr(mem_fp_wr), .i_mem_rd(mem_rd),
    .i_wb_wr(wb_fp_wr), .i_wb_rd(wb_rd),
    .o_sel(forward_z)
  );

endmodule

// File: doc/fpu_hazard_ctrl.md
Name: fpu_hazard_ctrl

Overview:
Hazard and sequencing controller for the FP execute stage. It drives the 2-bit X/Y/Z operand-forwarding selects of the FPU input mux and stalls decode on FP load-use hazards. It also sequences the iterative FDIV/FSQRT unit: start pulse, busy count and completion. It sits between the ID/EX pipeline register and the FPU operand mux, and holds its own registered copy of the EX-stage source specifiers.

Parameters:
MC_CYCLES, 12, execute cycles of the iterative FDIV/FSQRT unit, counted from the start pulse (valid range 2..63).
REG_AW, 5, FP register index width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
flush  in  1  pipeline flush (branch or trap); kills the EX entry and any multi-cycle op
id_valid  in  1  a valid instruction is in ID
id_rs1, id_rs2, id_rs3  in  REG_AW  FP source indices in ID
id_use_rs1, id_use_rs2, id_use_rs3  in  1  the corresponding source is read
id_is_mc  in  1  the ID instruction is FDIV.S or FSQRT.S
ex_is_fload  in  1  the instruction in EX is FLW
ex_rd  in  REG_AW  EX destination
mem_fp_wr, wb_fp_wr  in  1  the MEM or WB stage writes the FP register file
mem_rd, wb_rd  in  REG_AW  MEM or WB destination
forward_x, forward_y, forward_z  out  2  00 = register file, 01 = WB, 10 = MEM; 11 is never driven
stall_id  out  1  hold the IF/ID stages and insert an EX bubble
mc_start  out  1  one-cycle start pulse to the FDIV/FSQRT unit
mc_busy  out  1  a multi-cycle op is in flight
mc_done  out  1  one-cycle completion pulse; the result is valid at the FPU output this cycle

Behaviour:
- Reset (rst_n=0 sampled at an edge): ex_use1..3=0, ex_rs1..3=0, ex_mc=0, FSM=IDLE, count=0.
- Reset values of the outputs: forward_* = 00, stall_id = 0, mc_start = 0, mc_busy = 0, mc_done = 0.
- Reset asserted mid-operation aborts the op immediately; mc_done does not pulse.
- EX capture, when id_valid & !stall_id & !flush: ex_rs_k <= id_rs_k, ex_use_k <= id_use_k, ex_mc <= id_is_mc.
- EX bubble: when flush, or when stall_id while the FSM is IDLE, clear ex_use1..3 and ex_mc.
- EX hold: while the FSM is BUSY, the EX registers hold.
- Forwarding is combinational from the EX registers, evaluated per operand k:
  - 10 if ex_use_k & mem_fp_wr & mem_rd==ex_rs_k;
  - else 01 if ex_use_k & wb_fp_wr & wb_rd==ex_rs_k;
  - else 00.
  - MEM has priority over WB.
  - f0 is a real register: no zero-index exclusion.
- Load-use stall, lu = id_valid & ex_is_fload & OR_k(id_use_k & id_rs_k==ex_rd). lu lasts exactly 1 cycle; the following cycle EX holds a bubble.
- stall_id = lu | (FSM==BUSY) | (FSM==IDLE & ex_mc & !flush).
- FSM IDLE:
  - if ex_mc & !flush, assert mc_start and set count <= MC_CYCLES-1, then go to BUSY.
  - ex_mc is cleared on that edge because of the stall bubble.
- FSM BUSY:
  - mc_busy=1.
  - if flush, go to IDLE with no mc_done.
  - else if count==1, go to DONE.
  - else count <= count-1.
- FSM DONE:
  - mc_done=1, mc_busy=0, stall_id=lu.
  - next state is IDLE unconditionally.
  - flush in DONE still completes, because writeback is already committed.
- Total stall for one FDIV = MC_CYCLES cycles: the issue cycle plus MC_CYCLES-1 BUSY cycles. mc_done falls MC_CYCLES cycles after mc_start.
- Simultaneous flush and lu: flush wins; stall_id may still be 1 that cycle but the EX entry is killed.
- A back-to-back FDIV in ID during DONE captures normally and starts on the next cycle.
- count width is 6 bits; no wrap, because the FSM leaves BUSY at 1.

Decomposition:
- Shared package fpu_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, also used by the mux and the forwarding checks;
  - FSM state encoding IDLE/BUSY/DONE (2-bit);
  - REG_AW default.
- One natural sub-module, fpu_fwd_sel: the per-operand combinational comparator, instantiated 3 times for X, Y and Z.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0 and forward_* = 00.
- Forward priority: EX rs1=f3 used, mem_rd=f3 with mem_fp_wr=1, wb_rd=f3 with wb_fp_wr=1 -> forward_x=10. Drop mem_fp_wr -> forward_x=01. Unused rs2=f3 -> forward_y=00.
- Load-use: ex_is_fload, ex_rd=f7, ID rs3=f7 used -> stall_id=1 for exactly 1 cycle. Next cycle the EX bubble gives forward_z=00, and the cycle after captures rs3=f7.
- FDIV, MC_CYCLES=12: mc_start at cycle t; mc_busy over t+1..t+11; mc_done at t+12; stall_id=1 over t..t+11 and 0 at t+12.
- Flush mid-op: flush at t+5 -> IDLE at t+6, no mc_done, stall_id=0 at t+6.
- Back-to-back FDIV with MC_CYCLES=2: the second op issued during DONE -> second mc_start exactly 1 cycle after the first mc_done.
